// File: rtl/field_hw_arb.sv
// field_hw_arb: round-robin arbiter serialising N hardware agents onto
// one register field's hw_pulse/hw_value update path.
module field_hw_arb #(
    parameter int N_REQ   = 4,
    parameter int F_WIDTH = 4,
    parameter int GAP_W   = 4,
    parameter int MERGE   = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ*F_WIDTH-1:0]   req_value,
    input  logic                       sw_busy,
    input  logic [GAP_W-1:0]           gap_cfg,
    output logic                       hw_pulse,
    output logic [F_WIDTH-1:0]         hw_value,
    output logic [N_REQ-1:0]           ack,
    output logic [$clog2(N_REQ)-1:0]   grant_id,
    output logic                       busy
);

    localparam int ID_W = $clog2(N_REQ);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PULSE = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [ID_W-1:0]    r_ptr;
    logic [ID_W-1:0]    w_ptr_nxt;
    logic [GAP_W-1:0]   r_gap_cnt;
    logic [GAP_W-1:0]   w_gap_nxt;
    logic               r_pulse;
    logic               w_pulse_nxt;
    logic [F_WIDTH-1:0] r_value;
    logic [F_WIDTH-1:0] w_value_nxt;
    logic [N_REQ-1:0]   r_ack;
    logic [N_REQ-1:0]   w_ack_nxt;
    logic [ID_W-1:0]    r_gid;
    logic [ID_W-1:0]    w_gid_nxt;

    logic [N_REQ-1:0]   w_elig;
    logic [N_REQ-1:0]   w_win;
    logic [F_WIDTH-1:0] w_win_val;
    logic [ID_W-1:0]    w_win_id;
    logic               w_found;

    // Winner selection: rotating search from the pointer, or all eligible in merge mode
    always_comb begin
        w_elig    = req & ~r_ack;
        w_win     = '0;
        w_win_val = '0;
        w_win_id  = '0;
        w_found   = 1'b0;
        if (MERGE != 0) begin
            w_win   = w_elig;
            w_found = |w_elig;
            for (int i = N_REQ - 1; i >= 0; i--) begin
                if (w_elig[i]) begin
                    w_win_id = ID_W'(i);
                end
            end
        end else begin
            for (int k = 0; k < N_REQ; k++) begin
                if (!w_found && w_elig[ID_W'((int'(r_ptr) + k) % N_REQ)]) begin
                    w_found  = 1'b1;
                    w_win_id = ID_W'((int'(r_ptr) + k) % N_REQ);
                end
            end
            if (w_found) begin
                w_win = {{(N_REQ-1){1'b0}}, 1'b1} << w_win_id;
            end
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (w_win[i]) begin
                w_win_val = w_win_val | req_value[i*F_WIDTH +: F_WIDTH];
            end
        end
    end

    // Next-state and next-output logic for the IDLE/PULSE/GAP sequencer
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_gap_nxt   = r_gap_cnt;
        w_pulse_nxt = 1'b0;
        w_value_nxt = '0;
        w_ack_nxt   = '0;
        w_gid_nxt   = '0;
        unique case (r_state)
            S_IDLE: begin
                if (!sw_busy && w_found) begin
                    w_state_nxt = S_PULSE;
                    w_pulse_nxt = 1'b1;
                    w_value_nxt = w_win_val;
                    w_ack_nxt   = w_win;
                    w_gid_nxt   = w_win_id;
                    w_gap_nxt   = gap_cfg;
                    if (MERGE == 0) begin
                        if (w_win_id == ID_W'(N_REQ - 1)) begin
                            w_ptr_nxt = '0;
                        end else begin
                            w_ptr_nxt = w_win_id + 1'b1;
                        end
                    end
                end
            end
            S_PULSE: begin
                if (r_gap_cnt != '0) begin
                    w_state_nxt = S_GAP;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_GAP: begin
                if (r_gap_cnt != '0) begin
                    w_gap_nxt = r_gap_cnt - 1'b1;
                end
                if (r_gap_cnt <= GAP_W'(1)) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State, pointer, gap counter and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_ptr     <= '0;
            r_gap_cnt <= '0;
            r_pulse   <= 1'b0;
            r_value   <= '0;
            r_ack     <= '0;
            r_gid     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_ptr     <= w_ptr_nxt;
            r_gap_cnt <= w_gap_nxt;
            r_pulse   <= w_pulse_nxt;
            r_value   <= w_value_nxt;
            r_ack     <= w_ack_nxt;
            r_gid     <= w_gid_nxt;
        end
    end

    assign hw_pulse = r_pulse;
    assign hw_value = r_value;
    assign ack      = r_ack;
    assign grant_id = r_gid;
    assign busy     = (r_state != S_IDLE);

`ifndef SYNTHESIS
    // Merge mode is limited to 16 agents
    a_cfg: assert property (@(posedge clk) !(MERGE != 0 && N_REQ > 16))
        else $error("field_hw_arb: MERGE=1 requires N_REQ <= 16");

    for (genvar g = 0; g < N_REQ; g++) begin : g_hold
        // A requester must hold req until it sees its ack
        a_hold: assert property (@(posedge clk) disable iff (!rst_n)
            (req[g] && !ack[g]) |=> req[g])
            else $error("field_hw_arb: req[%0d] dropped before ack", g);
    end
`endif

endmodule

// File: tb/tb_field_hw_arb.sv
// tb_field_hw_arb: directed test of field_hw_arb, round-robin and merge
// instances, with hand-computed expected values.
module tb_field_hw_arb;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [15:0] req_value;
    logic        sw_busy;
    logic [3:0]  gap_cfg;
    logic        hw_pulse;
    logic [3:0]  hw_value;
    logic [3:0]  ack;
    logic [1:0]  grant_id;
    logic        busy;

    logic [3:0]  m_req;
    logic [15:0] m_value;
    logic        m_sw_busy;
    logic [3:0]  m_gap_cfg;
    logic        m_pulse;
    logic [3:0]  m_hw_value;
    logic [3:0]  m_ack;
    logic [1:0]  m_gid;
    logic        m_busy;

    int n_checks = 0;
    int n_errors = 0;

    field_hw_arb #(.N_REQ(4), .F_WIDTH(4), .GAP_W(4), .MERGE(0)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_value(req_value),
        .sw_busy(sw_busy), .gap_cfg(gap_cfg), .hw_pulse(hw_pulse),
        .hw_value(hw_value), .ack(ack), .grant_id(grant_id), .busy(busy)
    );

    field_hw_arb #(.N_REQ(4), .F_WIDTH(4), .GAP_W(4), .MERGE(1)) dut_m (
        .clk(clk), .rst_n(rst_n), .req(m_req), .req_value(m_value),
        .sw_busy(m_sw_busy), .gap_cfg(m_gap_cfg), .hw_pulse(m_pulse),
        .hw_value(m_hw_value), .ack(m_ack), .grant_id(m_gid), .busy(m_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic p, input logic [3:0] v,
                           input logic [3:0] a, input logic [1:0] id,
                           input logic b);
        check({tag, ".pulse"}, 32'(hw_pulse), 32'(p));
        check({tag, ".value"}, 32'(hw_value), 32'(v));
        check({tag, ".ack"},   32'(ack),      32'(a));
        check({tag, ".gid"},   32'(grant_id), 32'(id));
        check({tag, ".busy"},  32'(busy),     32'(b));
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    logic [3:0] t2_val [4];
    int         t2_ord [5];

    initial begin
        t2_val = '{4'hA, 4'hB, 4'hC, 4'hD};
        t2_ord = '{0, 1, 2, 3, 0};
        rst_n = 1'b0; req = '0; req_value = '0; sw_busy = 1'b0; gap_cfg = '0;
        m_req = '0; m_value = '0; m_sw_busy = 1'b0; m_gap_cfg = '0;
        repeat (3) tick();
        chk_out("rst", 1'b0, 4'h0, 4'h0, 2'd0, 1'b0);
        check("rst.m_pulse", 32'(m_pulse), 32'd0);
        check("rst.m_busy", 32'(m_busy), 32'd0);
        rst_n = 1'b1;
        tick();
        tick();

        // single request, no competition
        req_value = 16'h0900;
        req = 4'b0100;
        tick();
        chk_out("t1.pulse", 1'b1, 4'h9, 4'b0100, 2'd2, 1'b1);
        tick();
        chk_out("t1.after", 1'b0, 4'h0, 4'h0, 2'd0, 1'b0);
        req = '0;

        // all four held: rotation 0,1,2,3,0
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        req_value = 16'hDCBA;
        req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            tick();
            chk_out($sformatf("t2.pulse%0d", g), 1'b1, t2_val[t2_ord[g]],
                    4'(1 << t2_ord[g]), 2'(t2_ord[g]), 1'b1);
            tick();
            chk_out($sformatf("t2.idle%0d", g), 1'b0, 4'h0, 4'h0, 2'd0, 1'b0);
            if (g != 0) req[t2_ord[g]] = 1'b0;
        end

        // programmable gap of 3 cycles
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        gap_cfg = 4'd3;
        req_value = 16'h0021;
        req = 4'b0011;
        tick();
        chk_out("t3.pulse0", 1'b1, 4'h1, 4'b0001, 2'd0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_out($sformatf("t3.gap%0d", i), 1'b0, 4'h0, 4'h0, 2'd0, 1'b1);
            if (i == 0) req[0] = 1'b0;
        end
        tick();
        chk_out("t3.idle", 1'b0, 4'h0, 4'h0, 2'd0, 1'b0);
        gap_cfg = 4'd0;
        tick();
        chk_out("t3.pulse1", 1'b1, 4'h2, 4'b0010, 2'd1, 1'b1);
        tick();
        req[1] = 1'b0;
        repeat (3) tick();
        chk_out("t3.end", 1'b0, 4'h0, 4'h0, 2'd0, 1'b0);

        // software access blocks grants for 4 cycles
        req_value = 16'h5000;
        sw_busy = 1'b1;
        req = 4'b1000;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_out($sformatf("t4.blk%0d", i), 1'b0, 4'h0, 4'h0, 2'd0, 1'b0);
        end
        sw_busy = 1'b0;
        tick();
        chk_out("t4.pulse", 1'b1, 4'h5, 4'b1000, 2'd3, 1'b1);
        tick();
        chk_out("t4.after", 1'b0, 4'h0, 4'h0, 2'd0, 1'b0);
        req = '0;

        // merge instance: OR of values, all contributors acked
        m_value = 16'h8F1F;
        m_req = 4'b1010;
        tick();
        check("t5.pulse", 32'(m_pulse), 32'd1);
        check("t5.value", 32'(m_hw_value), 32'h9);
        check("t5.ack", 32'(m_ack), 32'b1010);
        check("t5.gid", 32'(m_gid), 32'd1);
        tick();
        check("t5.after_pulse", 32'(m_pulse), 32'd0);
        check("t5.after_ack", 32'(m_ack), 32'd0);
        m_req = '0;

        // reset during GAP with req2 held
        gap_cfg = 4'd2;
        req_value = 16'h0600;
        req = 4'b0100;
        tick();
        chk_out("t6.pulse", 1'b1, 4'h6, 4'b0100, 2'd2, 1'b1);
        gap_cfg = 4'd0;
        tick();
        chk_out("t6.gap", 1'b0, 4'h0, 4'h0, 2'd0, 1'b1);
        rst_n = 1'b0;
        tick();
        chk_out("t6.rst", 1'b0, 4'h0, 4'h0, 2'd0, 1'b0);
        rst_n = 1'b1;
        tick();
        chk_out("t6.regrant", 1'b1, 4'h6, 4'b0100, 2'd2, 1'b1);
        tick();
        chk_out("t6.after", 1'b0, 4'h0, 4'h0, 2'd0, 1'b0);
        req = '0;
        repeat (2) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
